// File: rtl/rule_cfg_pkg.sv
// rule_cfg_pkg
//   Shared definitions for the type-lookup rule loader: table geometry,
//   rule record layout, config header layout and opcodes.
//   The rule record is packed LSB-first in the order valid, typeData,
//   typeMask, keyOffset, keyMergeOffset, headShift, metaShift. A packed
//   struct lists its first member at the MSB, so the members below appear
//   in reverse order.
package rule_cfg_pkg;

  localparam int WORD_BITS        = 32;
  localparam int RULE_NUM         = 4;
  localparam int TYPE_NUM         = 2;
  localparam int TYPE_WIDTH       = 16;
  localparam int KEY_FILED_NUM    = 2;
  localparam int KEY_OFFSET_WIDTH = 6;
  localparam int HEAD_SHIFT_WIDTH = 8;
  localparam int META_SHIFT_WIDTH = 8;

  localparam int TYPE_BITS      = TYPE_NUM * TYPE_WIDTH;
  localparam int KEY_OFF_BITS   = KEY_FILED_NUM * (KEY_OFFSET_WIDTH + 1);
  localparam int KEY_MERGE_BITS = KEY_FILED_NUM * KEY_OFFSET_WIDTH;
  localparam int RULE_BITS      = 1 + 2 * TYPE_BITS + KEY_OFF_BITS + KEY_MERGE_BITS
                                  + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
  // P: number of payload words needed to carry one rule record
  localparam int RULE_WORDS     = (RULE_BITS + WORD_BITS - 1) / WORD_BITS;
  localparam int RULE_IDX_W     = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
  localparam int WORD_CNT_W     = (RULE_WORDS > 1) ? $clog2(RULE_WORDS) : 1;

  // Any other opcode value is rejected.
  typedef enum logic [3:0] {
    OP_WRITE     = 4'd1,
    OP_CLEAR_ALL = 4'd2
  } cfg_opcode_e;

  // Header word with bits [27:24] dropped (they carry no meaning).
  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] layer;
    logic [7:0] rule_idx;
    logic [7:0] word_cnt;
  } cfg_hdr_t;

  typedef struct packed {
    logic [META_SHIFT_WIDTH-1:0] meta_shift;
    logic [HEAD_SHIFT_WIDTH-1:0] head_shift;
    logic [KEY_MERGE_BITS-1:0]   key_merge_offset;
    logic [KEY_OFF_BITS-1:0]     key_offset;
    logic [TYPE_BITS-1:0]        type_mask;
    logic [TYPE_BITS-1:0]        type_data;
    logic                        valid;
  } rule_rec_t;

  function automatic logic [RULE_NUM-1:0] rule_onehot(input logic [RULE_IDX_W-1:0] idx);
    return RULE_NUM'(1) << idx;
  endfunction

endpackage

// File: rtl/rule_payload_shifter.sv
// rule_payload_shifter
//   Collects RULE_WORDS config words into one rule record. Each shifted
//   word enters at the top and moves down, so after RULE_WORDS shifts the
//   first word sits at bits [31:0].
// Ports
//   i_clk       clock
//   i_clr       synchronous clear of the word buffer
//   i_shift_en  shift i_word in on this edge
//   i_word      incoming config word
//   o_rec_next  record as it will read after this edge (shifted value when
//               i_shift_en is high, current contents otherwise)
module rule_payload_shifter
  import rule_cfg_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_clr,
  input  logic                 i_shift_en,
  input  logic [WORD_BITS-1:0] i_word,
  output logic [RULE_BITS-1:0] o_rec_next
);

  logic [RULE_WORDS-1:0][WORD_BITS-1:0] words_reg;
  logic [RULE_WORDS-1:0][WORD_BITS-1:0] words_next;

  genvar gi;
  generate
    for (gi = 0; gi < RULE_WORDS; gi++) begin : g_word
      if (gi == RULE_WORDS - 1) begin : g_top
        assign words_next[gi] = i_shift_en ? i_word : words_reg[gi];
      end else begin : g_mid
        assign words_next[gi] = i_shift_en ? words_reg[gi+1] : words_reg[gi];
      end
    end
  endgenerate

  // Unused top bits of the last word are simply not forwarded.
  assign o_rec_next = words_next[RULE_BITS-1:0];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      words_reg <= '0;
    end else begin
      words_reg <= words_next;
    end
  end

endmodule

// File: rtl/type_rule_loader.sv
// type_rule_loader
//   Config-side writer for one layer's type-lookup rule table. Decodes
//   WRITE / CLEAR_ALL commands from a 32-bit valid/ready word stream,
//   assembles a rule record and emits a single-cycle one-hot write strobe
//   with the record fields. Commands for other layers are drained quietly;
//   malformed commands are drained and flagged on o_err.
// Optional feature (macro CFG_CHECKSUM_EN): a WRITE carries one trailing
//   word equal to the XOR of the header and all payload words; a mismatch
//   suppresses the write and pulses o_err.
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cfg_valid/i_cfg_data       config word stream in
//   o_cfg_ready                  word accepted when valid & ready
//   o_rule_wren                  one-hot row write strobe (1 cycle)
//   o_typeRule_*                 rule record fields for the table
//   o_err                        1-cycle pulse per rejected command
//   o_wr_cnt                     committed row-write counter (wraps)
module type_rule_loader
  import rule_cfg_pkg::*;
#(
  parameter int         CFG_WIDTH = 32,
  parameter logic [7:0] LAYER_ID  = 8'd0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cfg_valid,
  input  logic [CFG_WIDTH-1:0]        i_cfg_data,
  output logic                        o_cfg_ready,
  output logic [RULE_NUM-1:0]         o_rule_wren,
  output logic                        o_typeRule_valid,
  output logic [TYPE_BITS-1:0]        o_typeRule_typeData,
  output logic [TYPE_BITS-1:0]        o_typeRule_typeMask,
  output logic [KEY_OFF_BITS-1:0]     o_typeRule_keyOffset,
  output logic [KEY_MERGE_BITS-1:0]   o_typeRule_keyMergeOffset,
  output logic [HEAD_SHIFT_WIDTH-1:0] o_typeRule_headShift,
  output logic [META_SHIFT_WIDTH-1:0] o_typeRule_metaShift,
  output logic                        o_err,
  output logic [15:0]                 o_wr_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RECV, ST_CHK, ST_COMMIT, ST_CLEAR, ST_DRAIN
  } state_e;

  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(RULE_WORDS - 1);
  localparam logic [RULE_IDX_W-1:0] LAST_RULE = RULE_IDX_W'(RULE_NUM - 1);

  state_e                  state_reg;
  logic                    ready_reg;
  logic [RULE_NUM-1:0]     wren_reg;
  rule_rec_t               rec_reg;
  logic                    err_reg;
  logic [15:0]             wr_cnt_reg;
  logic [RULE_IDX_W-1:0]   idx_reg;
  logic [WORD_CNT_W-1:0]   word_cnt_reg;
  logic [8:0]              drain_cnt_reg;
  logic [RULE_IDX_W-1:0]   clr_cnt_reg;
`ifdef CFG_CHECKSUM_EN
  logic [CFG_WIDTH-1:0]    csum_reg;
`endif

  cfg_hdr_t                hdr;
  logic                    accept;
  logic                    shift_en;
  logic [8:0]              drain_len;
  logic [RULE_BITS-1:0]    rec_next;

  assign hdr      = {i_cfg_data[31:28], i_cfg_data[23:0]};
  assign accept   = i_cfg_valid & ready_reg;
  assign shift_en = accept & (state_reg == ST_RECV);

  // Words to discard after a header that is not taken: the payload, plus
  // the checksum word that always trails a WRITE when checksums are on.
  always_comb begin
    drain_len = {1'b0, hdr.word_cnt};
`ifdef CFG_CHECKSUM_EN
    if (hdr.opcode == OP_WRITE) begin
      drain_len = drain_len + 9'd1;
    end
`endif
  end

  rule_payload_shifter u_shifter (
    .i_clk      (i_clk),
    .i_clr      (i_rst),
    .i_shift_en (shift_en),
    .i_word     (i_cfg_data),
    .o_rec_next (rec_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      ready_reg     <= 1'b1;
      wren_reg      <= '0;
      rec_reg       <= '0;
      err_reg       <= 1'b0;
      wr_cnt_reg    <= '0;
      idx_reg       <= '0;
      word_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      clr_cnt_reg   <= '0;
`ifdef CFG_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else begin
      err_reg  <= 1'b0;
      wren_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (hdr.opcode == OP_WRITE && hdr.layer == LAYER_ID &&
                hdr.rule_idx < 8'(RULE_NUM) && hdr.word_cnt == 8'(RULE_WORDS)) begin
              state_reg    <= ST_RECV;
              idx_reg      <= hdr.rule_idx[RULE_IDX_W-1:0];
              word_cnt_reg <= '0;
`ifdef CFG_CHECKSUM_EN
              csum_reg     <= i_cfg_data;
`endif
            end else if (hdr.opcode == OP_CLEAR_ALL && hdr.layer == LAYER_ID &&
                         hdr.word_cnt == 8'd0) begin
              // Row 0 is written straight away; the CLEAR state walks the rest.
              state_reg   <= ST_CLEAR;
              ready_reg   <= 1'b0;
              clr_cnt_reg <= '0;
              wren_reg    <= rule_onehot('0);
              rec_reg     <= '0;
              wr_cnt_reg  <= wr_cnt_reg + 16'd1;
            end else if (hdr.opcode != OP_WRITE && hdr.opcode != OP_CLEAR_ALL) begin
              err_reg <= 1'b1;
            end else begin
              // Known opcode not taken: another layer's command drains
              // silently, a malformed one for this layer is flagged.
              err_reg <= (hdr.layer == LAYER_ID);
              if (drain_len != 9'd0) begin
                state_reg     <= ST_DRAIN;
                drain_cnt_reg <= drain_len;
              end
            end
          end
        end

        ST_RECV: begin
          if (accept) begin
            word_cnt_reg <= word_cnt_reg + WORD_CNT_W'(1);
`ifdef CFG_CHECKSUM_EN
            csum_reg <= csum_reg ^ i_cfg_data;
            if (word_cnt_reg == LAST_WORD) begin
              state_reg <= ST_CHK;
            end
`else
            if (word_cnt_reg == LAST_WORD) begin
              // rec_next already includes the word accepted on this edge.
              state_reg  <= ST_COMMIT;
              ready_reg  <= 1'b0;
              wren_reg   <= rule_onehot(idx_reg);
              rec_reg    <= rec_next;
              wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end
`endif
          end
        end

`ifdef CFG_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            if (i_cfg_data == csum_reg) begin
              state_reg  <= ST_COMMIT;
              ready_reg  <= 1'b0;
              wren_reg   <= rule_onehot(idx_reg);
              rec_reg    <= rec_next;
              wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end else begin
              state_reg <= ST_IDLE;
              err_reg   <= 1'b1;
            end
          end
        end
`endif

        ST_COMMIT: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end

        ST_CLEAR: begin
          if (clr_cnt_reg == LAST_RULE) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + RULE_IDX_W'(1);
            wren_reg    <= rule_onehot(clr_cnt_reg + RULE_IDX_W'(1));
            wr_cnt_reg  <= wr_cnt_reg + 16'd1;
          end
        end

        ST_DRAIN: begin
          if (accept) begin
            if (drain_cnt_reg == 9'd1) begin
              state_reg <= ST_IDLE;
            end
            drain_cnt_reg <= drain_cnt_reg - 9'd1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign o_cfg_ready               = ready_reg;
  assign o_rule_wren               = wren_reg;
  assign o_typeRule_valid          = rec_reg.valid;
  assign o_typeRule_typeData       = rec_reg.type_data;
  assign o_typeRule_typeMask       = rec_reg.type_mask;
  assign o_typeRule_keyOffset      = rec_reg.key_offset;
  assign o_typeRule_keyMergeOffset = rec_reg.key_merge_offset;
  assign o_typeRule_headShift      = rec_reg.head_shift;
  assign o_typeRule_metaShift      = rec_reg.meta_shift;
  assign o_err                     = err_reg;
  assign o_wr_cnt                  = wr_cnt_reg;

endmodule

// File: tb/tb_type_rule_loader.sv
module tb_type_rule_loader;
  import rule_cfg_pkg::*;

  localparam logic [7:0] LAYER = 8'd3;
  localparam int PL_BITS = RULE_WORDS * 32;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid;
  logic [31:0] cfg_data;
  logic cfg_ready;
  logic [RULE_NUM-1:0] wren;
  logic tr_valid;
  logic [TYPE_BITS-1:0] tr_data, tr_mask;
  logic [KEY_OFF_BITS-1:0] tr_koff;
  logic [KEY_MERGE_BITS-1:0] tr_kmo;
  logic [HEAD_SHIFT_WIDTH-1:0] tr_head;
  logic [META_SHIFT_WIDTH-1:0] tr_meta;
  logic err;
  logic [15:0] wr_cnt;

  always #5 clk = ~clk;

  type_rule_loader #(.CFG_WIDTH(32), .LAYER_ID(LAYER)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .i_cfg_data(cfg_data),
    .o_cfg_ready(cfg_ready), .o_rule_wren(wren), .o_typeRule_valid(tr_valid),
    .o_typeRule_typeData(tr_data), .o_typeRule_typeMask(tr_mask),
    .o_typeRule_keyOffset(tr_koff), .o_typeRule_keyMergeOffset(tr_kmo),
    .o_typeRule_headShift(tr_head), .o_typeRule_metaShift(tr_meta),
    .o_err(err), .o_wr_cnt(wr_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed record, reassembled in the documented LSB-first field order.
  function automatic logic [RULE_BITS-1:0] obs_rec();
    return {tr_meta, tr_head, tr_kmo, tr_koff, tr_mask, tr_data, tr_valid};
  endfunction

  // Monitor: every cycle with a write strobe becomes an event.
  typedef struct {
    int                   cyc;
    logic [RULE_NUM-1:0]  wren;
    logic                 rdy;
    logic [RULE_BITS-1:0] rec;
    logic [15:0]          cnt;
  } wev_t;

  wev_t evq[$];
  int cyc = 0;
  int err_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (err === 1'b1) err_seen <= err_seen + 1;
    if (wren !== '0) begin
      evq.push_back('{cyc, wren, cfg_ready, obs_rec(), wr_cnt});
      chk("wren_onehot", 128'($countones(wren)), 128'd1);
    end
  end

  // Driver
  int last_acc = 0;
  int stalls = 0;
  int exp_cnt = 0;
  int txn = 0;
  logic [31:0] pl[$];

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    int t = 0;
    if (toggle) begin
      cfg_valid = 1'b0;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    @(negedge clk);
    while (cfg_ready !== 1'b1 && t < 40) begin
      t++;
      @(negedge clk);
    end
    if (cfg_ready !== 1'b1) chk("accept_timeout", 128'(cfg_ready), 128'd1);
    stalls += t;
    @(posedge clk); #1;
    last_acc  = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic fill_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back($urandom);
  endtask

  // Header, payload from pl, and (checksum builds) the trailing XOR word.
  task automatic send_cmd(input logic [3:0] op, input logic [7:0] layer, input logic [7:0] idx,
                          input logic [7:0] n, input bit toggle, input logic [31:0] csum_flip);
    logic [31:0] h;
    logic [31:0] x;
    h = {op, 4'h0, layer, idx, n};
    x = h ^ csum_flip;
    stalls = 0;
    send_word(h, toggle);
    for (int i = 0; i < int'(n); i++) begin
      send_word(pl[i], toggle);
      x ^= pl[i];
    end
`ifdef CFG_CHECKSUM_EN
    if (op == 4'd1) send_word(x, toggle);
`endif
    idle(RULE_NUM + 3);
  endtask

  task automatic expect_write(input string tag, input int e0, input int r0, input int idx);
    logic [PL_BITS-1:0] bits;
    wev_t ev;
    bits = '0;
    for (int i = 0; i < RULE_WORDS; i++) bits[i*32 +: 32] = pl[i];
    exp_cnt = (exp_cnt + 1) % 65536;
    chk({tag, "_nwren"}, 128'(evq.size() - e0), 128'd1);
    if (evq.size() > e0) begin
      ev = evq[e0];
      chk({tag, "_wren"}, 128'(ev.wren), 128'(1 << idx));
      chk({tag, "_rec"}, 128'(ev.rec), 128'(bits[RULE_BITS-1:0]));
      chk({tag, "_lat"}, 128'(ev.cyc), 128'(last_acc));
      chk({tag, "_cnt"}, 128'(ev.cnt), 128'(exp_cnt));
    end
    chk({tag, "_err"}, 128'(err_seen - r0), 128'd0);
    chk({tag, "_hold"}, 128'(obs_rec()), 128'(bits[RULE_BITS-1:0]));
    chk({tag, "_stall"}, 128'(stalls), 128'd0);
    $display("txn %0d %s: write idx=%0d wr_cnt=%0d", txn++, tag, idx, wr_cnt);
  endtask

  task automatic expect_reject(input string tag, input int e0, input int r0, input int exp_err);
    chk({tag, "_nwren"}, 128'(evq.size() - e0), 128'd0);
    chk({tag, "_err"}, 128'(err_seen - r0), 128'(exp_err));
    chk({tag, "_cnt"}, 128'(wr_cnt), 128'(exp_cnt));
    chk({tag, "_stall"}, 128'(stalls), 128'd0);
    chk({tag, "_rdy"}, 128'(cfg_ready), 128'd1);
    $display("txn %0d %s: rejected err=%0d wr_cnt=%0d", txn++, tag, err_seen - r0, wr_cnt);
  endtask

  task automatic expect_clear(input string tag, input int e0, input int r0);
    wev_t ev;
    int hdr_acc;
    hdr_acc = last_acc;
    chk({tag, "_nwren"}, 128'(evq.size() - e0), 128'(RULE_NUM));
    for (int k = 0; k < RULE_NUM && e0 + k < evq.size(); k++) begin
      ev = evq[e0 + k];
      exp_cnt = (exp_cnt + 1) % 65536;
      chk({tag, "_wren"}, 128'(ev.wren), 128'(1 << k));
      chk({tag, "_cyc"}, 128'(ev.cyc), 128'(hdr_acc + k));
      chk({tag, "_rec0"}, 128'(ev.rec), 128'd0);
      chk({tag, "_rdy0"}, 128'(ev.rdy), 128'd0);
      chk({tag, "_cnt"}, 128'(ev.cnt), 128'(exp_cnt));
    end
    chk({tag, "_err"}, 128'(err_seen - r0), 128'd0);
    $display("txn %0d %s: clear-all wr_cnt=%0d", txn++, tag, wr_cnt);
  endtask

  initial begin
    logic [PL_BITS-1:0] bits;
    int e0, r0, kind, idx, n;
    logic [3:0] op;
    logic [7:0] layer;

    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(cfg_ready), 128'd1);
    chk("rst_wren", 128'(wren), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_cnt", 128'(wr_cnt), 128'd0);
    chk("rst_rec", 128'(obs_rec()), 128'd0);
    idle(1);

    // Directed: valid=1, data=mask=0x0800 at row 2.
    bits = '0;
    bits[0] = 1'b1;
    bits[1 +: TYPE_BITS] = TYPE_BITS'(32'h0800);
    bits[1 + TYPE_BITS +: TYPE_BITS] = TYPE_BITS'(32'h0800);
    pl.delete();
    for (int i = 0; i < RULE_WORDS; i++) pl.push_back(bits[i*32 +: 32]);
    e0 = evq.size(); r0 = err_seen;
    send_cmd(4'd1, LAYER, 8'd2, 8'(RULE_WORDS), 1'b0, 32'h0);
    expect_write("dir_w2", e0, r0, 2);
    chk("dir_data", 128'(tr_data), 128'h0800);
    chk("dir_mask", 128'(tr_mask), 128'h0800);
    chk("dir_valid", 128'(tr_valid), 128'd1);

    // Same payload with valid toggling every cycle.
    e0 = evq.size(); r0 = err_seen;
    send_cmd(4'd1, LAYER, 8'd2, 8'(RULE_WORDS), 1'b1, 32'h0);
    expect_write("dir_toggle", e0, r0, 2);

    // Directed rejects.
    fill_payload(RULE_WORDS);
    e0 = evq.size(); r0 = err_seen;
    send_cmd(4'd1, LAYER, 8'(RULE_NUM), 8'(RULE_WORDS), 1'b0, 32'h0);
    expect_reject("dir_badidx", e0, r0, 1);
    e0 = evq.size(); r0 = err_seen;
    send_cmd(4'd1, LAYER + 8'd1, 8'd1, 8'(RULE_WORDS), 1'b0, 32'h0);
    expect_reject("dir_otherlayer", e0, r0, 0);

    e0 = evq.size(); r0 = err_seen;
    send_cmd(4'd2, LAYER, 8'd0, 8'd0, 1'b0, 32'h0);
    expect_clear("dir_clear", e0, r0);

`ifdef CFG_CHECKSUM_EN
    fill_payload(RULE_WORDS);
    e0 = evq.size(); r0 = err_seen;
    send_cmd(4'd1, LAYER, 8'd1, 8'(RULE_WORDS), 1'b0, 32'h1);
    expect_reject("csum_bad", e0, r0, 1);
    e0 = evq.size(); r0 = err_seen;
    send_cmd(4'd1, LAYER, 8'd1, 8'(RULE_WORDS), 1'b0, 32'h0);
    expect_write("csum_good", e0, r0, 1);
`endif

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 6);
      e0 = evq.size(); r0 = err_seen;
      case (kind)
        0, 1: begin
          idx = $urandom_range(0, RULE_NUM - 1);
          fill_payload(RULE_WORDS);
          send_cmd(4'd1, LAYER, 8'(idx), 8'(RULE_WORDS), 1'($urandom_range(0, 1)), 32'h0);
          expect_write("rnd_write", e0, r0, idx);
        end
        2: begin
          fill_payload(RULE_WORDS);
          send_cmd(4'd1, LAYER, 8'($urandom_range(RULE_NUM, 255)), 8'(RULE_WORDS), 1'b0, 32'h0);
          expect_reject("rnd_badidx", e0, r0, 1);
        end
        3: begin
          op = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
          do n = $urandom_range(0, 7);
          while (n == ((op == 4'd1) ? RULE_WORDS : 0));
          fill_payload(n);
          send_cmd(op, LAYER, 8'($urandom_range(0, RULE_NUM - 1)), 8'(n), 1'b0, 32'h0);
          expect_reject("rnd_badlen", e0, r0, 1);
        end
        4: begin
          op = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
          layer = LAYER + 8'($urandom_range(1, 255));
          n = $urandom_range(0, 6);
          fill_payload(n);
          send_cmd(op, layer, 8'($urandom_range(0, 255)), 8'(n), 1'($urandom_range(0, 1)), 32'h0);
          expect_reject("rnd_otherlayer", e0, r0, 0);
        end
        5: begin
          do op = 4'($urandom_range(0, 15));
          while (op == 4'd1 || op == 4'd2);
          pl.delete();
          send_cmd(op, LAYER, 8'd0, 8'($urandom_range(0, 6)) & 8'h0, 1'b0, 32'h0);
          expect_reject("rnd_badop", e0, r0, 1);
        end
        default: begin
          send_cmd(4'd2, LAYER, 8'($urandom_range(0, 255)), 8'd0, 1'b0, 32'h0);
          expect_clear("rnd_clear", e0, r0);
        end
      endcase
    end

    // Reset in the middle of a payload: nothing written, buffer cleared.
    fill_payload(RULE_WORDS);
    e0 = evq.size();
    send_word({4'd1, 4'h0, LAYER, 8'd3, 8'(RULE_WORDS)}, 1'b0);
    send_word(pl[0], 1'b0);
    send_word(pl[1], 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(RULE_NUM + 3);
    exp_cnt = 0;
    chk("midrst_nwren", 128'(evq.size() - e0), 128'd0);
    chk("midrst_cnt", 128'(wr_cnt), 128'd0);
    chk("midrst_rdy", 128'(cfg_ready), 128'd1);
    chk("midrst_rec", 128'(obs_rec()), 128'd0);
    $display("txn %0d midrst: aborted write, wr_cnt=%0d", txn++, wr_cnt);

    fill_payload(RULE_WORDS);
    e0 = evq.size(); r0 = err_seen;
    send_cmd(4'd1, LAYER, 8'd3, 8'(RULE_WORDS), 1'b0, 32'h0);
    expect_write("post_rst", e0, r0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
